// File: rtl/icetap_rec_ctrl.sv
// icetap_rec_ctrl: recording sequencer for the icetap BRAM capture path (src_clk domain).
// Runs arm -> pre-trigger -> post-trigger -> done, drives RAM write/read strobes and
// addresses, and holds start/trigger/stop addresses for scan readout.
// Optional build macro: ICETAP_TRIG_COUNT_EN adds a trigger holdoff counter
// (accept on the trigger_count+1'th qualifying hit).
module icetap_rec_ctrl #(
  parameter int unsigned RECORD_DEPTH  = 256,
  parameter int unsigned RAM_ADDR_BITS = $clog2(RECORD_DEPTH)
) (
  input  logic                     src_clk,
  input  logic                     src_reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               trigger_pos,
  input  logic                     store_hit,
  input  logic                     trigger_hit,
  input  logic [7:0]               trigger_count,
  input  logic                     read_req_first,
  input  logic                     read_req_next,
  output logic                     ram_wr_ena,
  output logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
  output logic                     ram_rd_ena,
  output logic [RAM_ADDR_BITS-1:0] ram_rd_addr,
  output logic                     read_data_vld,
  output logic [1:0]               state,
  output logic [RAM_ADDR_BITS-1:0] start_addr,
  output logic [RAM_ADDR_BITS-1:0] trigger_addr,
  output logic [RAM_ADDR_BITS-1:0] stop_addr
);

  localparam int unsigned AW = RAM_ADDR_BITS;
  // Pre-trigger counter needs one extra bit so it can saturate at DEPTH.
  localparam int unsigned CW = RAM_ADDR_BITS + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CW-1:0] PRE_MID    = CW'(RECORD_DEPTH / 2);
  localparam logic [CW-1:0] PRE_LAST   = CW'(RECORD_DEPTH - 1);
  localparam logic [CW-1:0] PRE_FULL   = CW'(RECORD_DEPTH);
  localparam logic [AW-1:0] POST_FIRST = AW'(RECORD_DEPTH - 1);
  localparam logic [AW-1:0] POST_MID   = AW'(RECORD_DEPTH / 2 - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [CW-1:0] pre_need_q, pre_need_d;
  logic [AW-1:0] post_need_q, post_need_d;
  logic          wrap_q, wrap_d;
  logic          trig_seen_q, trig_seen_d;
  logic [AW-1:0] start_addr_q, start_addr_d;
  logic [AW-1:0] trigger_addr_q, trigger_addr_d;
  logic [AW-1:0] stop_addr_q, stop_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_ena_q, rd_ena_d;
  logic          rd_vld_q, rd_vld_d;

  logic          recording_c;
  logic          trig_qual_c;
  logic          cnt_ok_c;
  logic          trig_accept_c;
  logic          wr_ena_c;
  logic [AW-1:0] wr_ptr_inc_c;
  logic          wrap_inc_c;
  logic [AW-1:0] abort_stop_c;

`ifdef ICETAP_TRIG_COUNT_EN
  logic [7:0]    trig_cnt_q, trig_cnt_d;

  // Accept only once the holdoff count of qualifying hits has been seen.
  assign cnt_ok_c = (trig_cnt_q == trigger_count);
`else
  logic          unused_trigger_count;

  // Holdoff disabled: every qualifying hit is accepted.
  assign cnt_ok_c             = 1'b1;
  assign unused_trigger_count = ^trigger_count;
`endif

  // Trigger qualification and the zero-latency RAM write strobe.
  assign recording_c   = (state_q == ST_PRE) || (state_q == ST_POST);
  assign trig_qual_c   = (state_q == ST_PRE) && trigger_hit && (pre_cnt_q >= pre_need_q);
  assign trig_accept_c = trig_qual_c && cnt_ok_c;
  assign wr_ena_c      = ((state_q == ST_PRE) && (store_hit || trig_accept_c)) ||
                         ((state_q == ST_POST) && store_hit);

  // Pointer and wrap flag as they stand after this cycle's write; abort reports from these.
  assign wr_ptr_inc_c = wr_ptr_q + AW'(wr_ena_c);
  assign wrap_inc_c   = wrap_q || (wr_ena_c && (wr_ptr_q == {AW{1'b1}}));
  assign abort_stop_c = (wrap_inc_c || (wr_ptr_inc_c != '0)) ? (wr_ptr_inc_c - AW'(1)) : '0;

  // Next-state, pointer, address and readout logic.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    pre_cnt_d      = pre_cnt_q;
    post_cnt_d     = post_cnt_q;
    pre_need_d     = pre_need_q;
    post_need_d    = post_need_q;
    wrap_d         = wrap_q;
    trig_seen_d    = trig_seen_q;
    start_addr_d   = start_addr_q;
    trigger_addr_d = trigger_addr_q;
    stop_addr_d    = stop_addr_q;
    rd_addr_d      = rd_addr_q;
    rd_ena_d       = 1'b0;
    rd_vld_d       = rd_ena_q;
`ifdef ICETAP_TRIG_COUNT_EN
    trig_cnt_d     = trig_cnt_q;
`endif

    if (state_q == ST_DONE) begin
      if (read_req_first) begin
        rd_addr_d = start_addr_q;
        rd_ena_d  = 1'b1;
      end else if (read_req_next) begin
        rd_addr_d = rd_addr_q + AW'(1);
        rd_ena_d  = 1'b1;
      end
    end

    if (!recording_c) begin
      if (start) begin
        state_d     = ST_PRE;
        wr_ptr_d    = '0;
        pre_cnt_d   = '0;
        wrap_d      = 1'b0;
        trig_seen_d = 1'b0;
`ifdef ICETAP_TRIG_COUNT_EN
        trig_cnt_d  = '0;
`endif
        case (trigger_pos)
          2'd0: begin
            pre_need_d  = '0;
            post_need_d = POST_FIRST;
          end
          2'd2: begin
            pre_need_d  = PRE_LAST;
            post_need_d = '0;
          end
          default: begin
            pre_need_d  = PRE_MID;
            post_need_d = POST_MID;
          end
        endcase
      end
    end else begin
      if (wr_ena_c) begin
        wr_ptr_d = wr_ptr_inc_c;
        wrap_d   = wrap_inc_c;
      end
      if ((state_q == ST_PRE) && store_hit && (pre_cnt_q != PRE_FULL)) begin
        pre_cnt_d = pre_cnt_q + CW'(1);
      end

      if (abort) begin
        state_d      = ST_DONE;
        stop_addr_d  = abort_stop_c;
        start_addr_d = wrap_inc_c ? (abort_stop_c + AW'(1)) : '0;
        if (!trig_seen_q) begin
          trigger_addr_d = abort_stop_c;
        end
      end else if (trig_accept_c) begin
        trigger_addr_d = wr_ptr_q;
        trig_seen_d    = 1'b1;
        post_cnt_d     = post_need_q;
        if (post_need_q == '0) begin
          stop_addr_d  = wr_ptr_q;
          start_addr_d = wr_ptr_q + AW'(1);
          state_d      = ST_DONE;
        end else begin
          state_d      = ST_POST;
        end
      end else if ((state_q == ST_POST) && store_hit) begin
        post_cnt_d = post_cnt_q - AW'(1);
        if (post_cnt_q == AW'(1)) begin
          stop_addr_d  = wr_ptr_q;
          start_addr_d = wr_ptr_q + AW'(1);
          state_d      = ST_DONE;
        end
`ifdef ICETAP_TRIG_COUNT_EN
      end else if (trig_qual_c && (trig_cnt_q != 8'hFF)) begin
        trig_cnt_d = trig_cnt_q + 8'd1;
`endif
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      pre_cnt_q      <= '0;
      post_cnt_q     <= '0;
      pre_need_q     <= '0;
      post_need_q    <= '0;
      wrap_q         <= 1'b0;
      trig_seen_q    <= 1'b0;
      start_addr_q   <= '0;
      trigger_addr_q <= '0;
      stop_addr_q    <= '0;
      rd_addr_q      <= '0;
      rd_ena_q       <= 1'b0;
      rd_vld_q       <= 1'b0;
`ifdef ICETAP_TRIG_COUNT_EN
      trig_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      pre_cnt_q      <= pre_cnt_d;
      post_cnt_q     <= post_cnt_d;
      pre_need_q     <= pre_need_d;
      post_need_q    <= post_need_d;
      wrap_q         <= wrap_d;
      trig_seen_q    <= trig_seen_d;
      start_addr_q   <= start_addr_d;
      trigger_addr_q <= trigger_addr_d;
      stop_addr_q    <= stop_addr_d;
      rd_addr_q      <= rd_addr_d;
      rd_ena_q       <= rd_ena_d;
      rd_vld_q       <= rd_vld_d;
`ifdef ICETAP_TRIG_COUNT_EN
      trig_cnt_q     <= trig_cnt_d;
`endif
    end
  end

  assign ram_wr_ena    = wr_ena_c;
  assign ram_wr_addr   = wr_ptr_q;
  assign ram_rd_ena    = rd_ena_q;
  assign ram_rd_addr   = rd_addr_q;
  assign read_data_vld = rd_vld_q;
  assign state         = state_q;
  assign start_addr    = start_addr_q;
  assign trigger_addr  = trigger_addr_q;
  assign stop_addr     = stop_addr_q;

endmodule

// File: tb/tb_icetap_rec_ctrl.sv
// Bench for icetap_rec_ctrl at RECORD_DEPTH=8: directed recordings checked against a
// behavioural model every cycle, plus literal expectations per scenario.
module tb_icetap_rec_ctrl;

  localparam int unsigned D  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          src_reset, start, abort, store_hit, trigger_hit;
  logic          read_req_first, read_req_next;
  logic [1:0]    trigger_pos;
  logic [7:0]    trigger_count;
  logic          ram_wr_ena, ram_rd_ena, read_data_vld;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr, start_addr, trigger_addr, stop_addr;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;
  int q_wr[$];
  int q_rd[$];

  always #5 clk = ~clk;

  icetap_rec_ctrl #(.RECORD_DEPTH(D)) dut (
    .src_clk(clk), .src_reset(src_reset), .start(start), .abort(abort),
    .trigger_pos(trigger_pos), .store_hit(store_hit), .trigger_hit(trigger_hit),
    .trigger_count(trigger_count), .read_req_first(read_req_first),
    .read_req_next(read_req_next), .ram_wr_ena(ram_wr_ena), .ram_wr_addr(ram_wr_addr),
    .ram_rd_ena(ram_rd_ena), .ram_rd_addr(ram_rd_addr), .read_data_vld(read_data_vld),
    .state(state), .start_addr(start_addr), .trigger_addr(trigger_addr), .stop_addr(stop_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Logged address sequence must be (base+i) mod D for i = 0..n-1.
  task automatic check_seq(input string name, input int got[$], input int base, input int n);
    chk({name, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], (base + i) % D);
  endtask

  task automatic check_rec(input string name, input int st, input int sa, input int ta, input int pa);
    chk({name, "_state"}, state, st);
    chk({name, "_start"}, start_addr, sa);
    chk({name, "_trig"}, trigger_addr, ta);
    chk({name, "_stop"}, stop_addr, pa);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 0; abort = 0; read_req_first = 0; read_req_next = 0;
  endtask

  // Behavioural model: total write count drives pointer, wrap and stop address.
  int m_state = 0, m_wr = 0, m_pre = 0, m_pre_need = 0, m_post_need = 0, m_post_left = 0;
  int m_start = 0, m_trig = 0, m_stop = 0, m_rd = 0, m_tcnt = 0;
  bit m_trig_seen = 0, m_rd_ena = 0, m_vld = 0;

  always @(negedge clk) begin
    int ptr, st, p;
    bit qual, cnt_ok, acc, wexp;
    ptr  = m_wr % D;
    st   = m_state;
    qual = (st == 1) && (trigger_hit === 1'b1) && (m_pre >= m_pre_need);
`ifdef ICETAP_TRIG_COUNT_EN
    cnt_ok = (m_tcnt == int'(trigger_count));
`else
    cnt_ok = 1'b1;
`endif
    acc  = qual && cnt_ok;
    wexp = ((st == 1) && (store_hit || acc)) || ((st == 2) && store_hit);

    chk("state", state, m_state);
    chk("wr_ena", ram_wr_ena, int'(wexp));
    chk("wr_addr", ram_wr_addr, ptr);
    chk("rd_ena", ram_rd_ena, int'(m_rd_ena));
    chk("rd_addr", ram_rd_addr, m_rd);
    chk("rd_vld", read_data_vld, int'(m_vld));
    chk("start_addr", start_addr, m_start);
    chk("trigger_addr", trigger_addr, m_trig);
    chk("stop_addr", stop_addr, m_stop);
    if (ram_wr_ena === 1'b1) q_wr.push_back(int'(ram_wr_addr));
    if (ram_rd_ena === 1'b1) q_rd.push_back(int'(ram_rd_addr));

    if (src_reset) begin
      m_state = 0; m_wr = 0; m_pre = 0; m_pre_need = 0; m_post_need = 0; m_post_left = 0;
      m_start = 0; m_trig = 0; m_stop = 0; m_rd = 0; m_tcnt = 0;
      m_trig_seen = 0; m_rd_ena = 0; m_vld = 0;
    end else begin
      m_vld    = m_rd_ena;
      m_rd_ena = 0;
      if (st == 3 && (read_req_first || read_req_next)) begin
        m_rd_ena = 1;
        m_rd     = read_req_first ? m_start : (m_rd + 1) % D;
      end
      if (st == 0 || st == 3) begin
        if (start) begin
          p = (trigger_pos == 2'd0) ? 0 : (trigger_pos == 2'd2) ? D - 1 : D / 2;
          m_state = 1; m_wr = 0; m_pre = 0; m_tcnt = 0; m_trig_seen = 0;
          m_pre_need = p; m_post_need = D - 1 - p;
        end
      end else begin
        if (wexp) m_wr++;
        if (st == 1 && store_hit) m_pre = (m_pre + 1 > D) ? D : m_pre + 1;
        if (abort) begin
          m_state = 3;
          m_stop  = (m_wr == 0) ? 0 : (m_wr - 1) % D;
          m_start = (m_wr >= D) ? (m_stop + 1) % D : 0;
          if (!m_trig_seen) m_trig = m_stop;
        end else if (acc) begin
          m_trig = ptr; m_trig_seen = 1; m_post_left = m_post_need;
          if (m_post_need == 0) begin
            m_stop = ptr; m_start = (ptr + 1) % D; m_state = 3;
          end else begin
            m_state = 2;
          end
        end else if (st == 2 && store_hit) begin
          if (m_post_left == 1) begin
            m_stop = ptr; m_start = (ptr + 1) % D; m_state = 3;
          end
          m_post_left--;
        end else if (qual) begin
          m_tcnt++;
        end
      end
    end
  end

  // Watchdog: the run is cycle-driven, so this only fires if the bench stalls.
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    src_reset = 1; start = 0; abort = 0; trigger_pos = 0; trigger_count = 0;
    store_hit = 0; trigger_hit = 0; read_req_first = 0; read_req_next = 0;
    tick(); tick();
    check_rec("reset", 0, 0, 0, 0);
    chk("reset_rd_ena", ram_rd_ena, 0);
    chk("reset_vld", read_data_vld, 0);
    src_reset = 0;
    tick();

    // abort and read requests in IDLE do nothing
    abort = 1; read_req_first = 1; tick(); tick();
    chk("idle_abort_state", state, 0);
    chk("idle_read_ena", ram_rd_ena, 0);

    // 1: middle trigger on 6th pre-trigger cycle, request during recording ignored
    q_wr.delete(); q_rd.delete();
    trigger_pos = 1; start = 1; tick();
    chk("t1_armed", state, 1);
    store_hit = 1; read_req_next = 1; tick();
    repeat (4) tick();
    trigger_hit = 1; tick(); trigger_hit = 0;
    chk("t1_post_state", state, 2);
    chk("t1_trig_addr", trigger_addr, 5);
    repeat (3) tick();
    tick(); store_hit = 0;
    check_rec("t1", 3, 1, 5, 0);
    check_seq("t1_wr", q_wr, 0, 9);
    chk("t1_no_read", q_rd.size(), 0);

    // 5: readout from the oldest sample, wrapping at the top
    q_rd.delete();
    read_req_first = 1; tick();
    repeat (7) begin read_req_next = 1; tick(); end
    tick(); tick();
    check_seq("t5_rd", q_rd, 1, 8);
    read_req_first = 1; read_req_next = 1; tick();
    chk("t5_first_wins_addr", ram_rd_addr, 1);
    chk("t5_first_wins_ena", ram_rd_ena, 1);
    tick();
    chk("t5_vld", read_data_vld, 1);

    // 2: trigger first, forced write with store_hit low; trigger_hit ignored afterwards
    q_wr.delete();
    trigger_pos = 0; start = 1; tick();
    trigger_hit = 1; store_hit = 0; tick();
    chk("t2_post_state", state, 2);
    chk("t2_trig_addr", trigger_addr, 0);
    store_hit = 1; repeat (7) tick(); store_hit = 0; trigger_hit = 0;
    check_rec("t2", 3, 0, 0, 7);
    check_seq("t2_wr", q_wr, 0, 8);

    // 3: trigger last, held high from the start
    q_wr.delete();
    trigger_pos = 2; start = 1; tick();
    store_hit = 1; trigger_hit = 1; repeat (7) tick();
    chk("t3_still_pre", state, 1);
    tick(); tick(); store_hit = 0; trigger_hit = 0;
    check_rec("t3", 3, 0, 7, 7);
    check_seq("t3_wr", q_wr, 0, 8);

    // 4: abort after 3 stores, no trigger
    q_wr.delete();
    trigger_pos = 1; start = 1; tick();
    store_hit = 1; repeat (3) tick(); store_hit = 0;
    abort = 1; tick();
    check_rec("t4", 3, 0, 2, 2);
    check_seq("t4_wr", q_wr, 0, 3);

    // start together with abort while recording: abort wins
    trigger_pos = 3; start = 1; tick();
    store_hit = 1; repeat (2) tick(); store_hit = 0;
    start = 1; abort = 1; tick();
    check_rec("t7", 3, 0, 1, 1);

    // abort after the buffer wrapped, with a write in the abort cycle
    q_wr.delete();
    trigger_pos = 2; start = 1; tick();
    store_hit = 1; repeat (10) tick();
    abort = 1; tick(); store_hit = 0;
    check_rec("t8", 3, 3, 2, 2);
    check_seq("t8_wr", q_wr, 0, 11);

    // 6: trigger holdoff (when built in), then reset during POST_TRIG
    q_wr.delete();
    trigger_count = 2; trigger_pos = 0; start = 1; tick();
`ifdef ICETAP_TRIG_COUNT_EN
    trigger_hit = 1; tick(); trigger_hit = 0; tick();
    trigger_hit = 1; tick(); trigger_hit = 0;
    chk("t6_held_off", state, 1);
    tick();
    trigger_hit = 1; tick(); trigger_hit = 0;
`else
    trigger_hit = 1; tick(); trigger_hit = 0;
`endif
    chk("t6_post_state", state, 2);
    chk("t6_trig_addr", trigger_addr, 0);
    check_seq("t6_wr", q_wr, 0, 1);
    store_hit = 1; tick(); tick(); store_hit = 0;
    chk("t6_recording", state, 2);
    src_reset = 1; tick(); src_reset = 0;
    check_rec("t6_reset", 0, 0, 0, 0);
    chk("t6_reset_wr_addr", ram_wr_addr, 0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
